// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_e;

   localparam int unsigned DEPTH_DEF = 32;
   localparam int unsigned IDX_W     = $clog2(DEPTH_DEF);

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input round-robin picker: on a tie the port opposite the last-served one wins.
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      if (&req_i) begin
         gnt_o = (last_i == PORT1) ? 2'b01 : 2'b10;
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with round-robin,
// bounded ownership lock, address filtering and registered responses.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic        m0_lock_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic        m1_lock_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        mem_we_o,
   output logic [31:0] mem_adr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]       rvalid_q, rvalid_d;
   logic [1:0]       err_q, err_d;
   logic [31:0]      rdata0_q, rdata0_d;
   logic [31:0]      rdata1_q, rdata1_d;

   logic [1:0]  req, pick, gnt;
   logic        sel, sel_we, sel_lock, sel_ok;
   logic [31:0] sel_adr, sel_wdata, rd_val;

   assign req = {m1_req_i, m0_req_i};

   dmem_rr_pick u_pick (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   always_comb begin
      gnt = '0;
      if (!rst_i) begin
         case (state_q)
            OWN0:    gnt = {1'b0, m0_req_i};
            OWN1:    gnt = {m1_req_i, 1'b0};
            default: gnt = pick;
         endcase
      end
   end

   // With no grant the memory side follows port 0.
   assign sel       = gnt[1];
   assign sel_adr   = sel ? m1_adr_i   : m0_adr_i;
   assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
   assign sel_we    = sel ? m1_we_i    : m0_we_i;
   assign sel_lock  = sel ? m1_lock_i  : m0_lock_i;
   assign sel_ok    = (sel_adr[1:0] == 2'b00) && ({2'b00, sel_adr[31:2]} < 32'(DEPTH));

   assign mem_we_o    = (|gnt) & sel_we & sel_ok;
   assign mem_adr_o   = {2'b00, sel_adr[31:2]};
   assign mem_wdata_o = sel_wdata;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      cnt_inc = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      if (|gnt) begin
         if ((state_q == IDLE) && (&req)) begin
            last_d = sel;
         end
         // The MAX_LOCK-th locked beat is served, then ownership is dropped
         // and the other port is favoured on the next tie.
         if (sel_lock && (cnt_inc != CNT_W'(MAX_LOCK))) begin
            state_d = sel ? OWN1 : OWN0;
            cnt_d   = cnt_inc;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            if (sel_lock) begin
               last_d = sel;
            end
         end
      end else if (state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      rd_val   = (!sel_we && sel_ok) ? mem_rdata_i : '0;
      rvalid_d = gnt;
      err_d    = gnt & {2{!sel_ok}};
      rdata0_d = gnt[0] ? rd_val : '0;
      rdata1_d = gnt[1] ? rd_val : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         last_q   <= PORT1;
         cnt_q    <= '0;
         rvalid_q <= '0;
         err_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign m0_gnt_o    = gnt[0];
   assign m1_gnt_o    = gnt[1];
   assign m0_rvalid_o = rvalid_q[0];
   assign m1_rvalid_o = rvalid_q[1];
   assign m0_err_o    = err_q[0];
   assign m1_err_o    = err_q[1];
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// every cycle against an ownership/preference model and a shadow memory.
module tb_dmem_arbiter;

   localparam int unsigned DEPTH    = 32;
   localparam int unsigned MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
   logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_we_o;
   logic [31:0] mem_adr_o, mem_wdata_o, mem_rdata_i;

   logic [31:0] phys_mem [DEPTH];
   logic [31:0] ref_mem  [DEPTH];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
      .m0_adr_i(m0_adr), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
      .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
      .m1_adr_i(m1_adr), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
      .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // Memory stand-in: combinational read, write on the clock edge.
   assign mem_rdata_i = (mem_adr_o < DEPTH) ? phys_mem[mem_adr_o[4:0]]
                                            : (32'hA5A5_0000 | mem_adr_o);
   always @(posedge clk) begin
      if (mem_we_o) phys_mem[mem_adr_o[4:0]] <= mem_wdata_o;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: owner (-1 none), consecutive locked beats of the owner, port that wins a tie.
   int          owner  = -1;
   int          run    = 0;
   int          prefer = 0;
   logic [1:0]  exp_rv  = '0;
   logic [1:0]  exp_err = '0;
   logic [31:0] exp_rd [2];

   task automatic model_step();
      logic [1:0]  req, we, lk;
      logic [31:0] adr [2];
      logic [31:0] wd  [2];
      int          g, s, idx;
      logic        ok;
      req = {m1_req, m0_req};
      we  = {m1_we, m0_we};
      lk  = {m1_lock, m0_lock};
      adr[0] = m0_adr;   adr[1] = m1_adr;
      wd[0]  = m0_wdata; wd[1]  = m1_wdata;
      if (rst)                g = -1;
      else if (owner >= 0)    g = req[owner] ? owner : -1;
      else if (req == 2'b11)  g = prefer;
      else if (req[0])        g = 0;
      else if (req[1])        g = 1;
      else                    g = -1;
      s   = (g == 1) ? 1 : 0;
      idx = int'(adr[s] >> 2);
      ok  = (adr[s][1:0] == 2'b00) && (idx < int'(DEPTH));
      chk("m0_gnt", 32'(m0_gnt_o), 32'(g == 0));
      chk("m1_gnt", 32'(m1_gnt_o), 32'(g == 1));
      chk("mem_we", 32'(mem_we_o), 32'((g >= 0) && we[s] && ok));
      chk("mem_adr", mem_adr_o, adr[s] >> 2);
      chk("mem_wdata", mem_wdata_o, wd[s]);
      exp_rv  = '0;
      exp_err = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      if (g >= 0) begin
         exp_rv[s]  = 1'b1;
         exp_err[s] = !ok;
         exp_rd[s]  = (!we[s] && ok) ? ref_mem[idx] : 32'h0;
         if (we[s] && ok) ref_mem[idx] = wd[s];
      end
      if (rst) begin
         owner = -1; run = 0; prefer = 0;
      end else if (g < 0) begin
         owner = -1; run = 0;
      end else begin
         if (owner < 0 && req == 2'b11) prefer = 1 - g;
         if (lk[s]) begin
            run++;
            if (run >= int'(MAX_LOCK)) begin
               owner = -1; run = 0; prefer = 1 - g;
            end else begin
               owner = g;
            end
         end else begin
            owner = -1; run = 0;
         end
      end
   endtask

   initial begin
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      forever begin
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
         chk("m0_rvalid", 32'(m0_rvalid_o), 32'(exp_rv[0]));
         chk("m1_rvalid", 32'(m1_rvalid_o), 32'(exp_rv[1]));
         if (exp_rv[0]) begin
            chk("m0_err", 32'(m0_err_o), 32'(exp_err[0]));
            chk("m0_rdata", m0_rdata_o, exp_rd[0]);
         end
         if (exp_rv[1]) begin
            chk("m1_err", 32'(m1_err_o), 32'(exp_err[1]));
            chk("m1_rdata", m1_rdata_o, exp_rd[1]);
         end
      end
   end

   // Driver
   logic g0 = 1'b0, g1 = 1'b0, wq = 1'b0;

   task automatic cyc();
      @(negedge clk);
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      wq = mem_we_o;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int p, input logic rq, input logic w, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         m0_req = rq; m0_we = w; m0_lock = lk; m0_adr = a; m0_wdata = d;
      end else begin
         m1_req = rq; m1_we = w; m1_lock = lk; m1_adr = a; m1_wdata = d;
      end
   endtask

   task automatic idle_all();
      drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      idle_all();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_adr();
      int unsigned k = $urandom_range(7);
      if (k < 6)       return {25'b0, 5'($urandom_range(31)), 2'b00};
      else if (k == 6) return ($urandom & ~32'h3) | 32'($urandom_range(3, 1));
      else             return $urandom | 32'h80;
   endfunction

   initial begin
      int n0, n1, beats, first1, m0_before;
      logic held;
      for (int i = 0; i < int'(DEPTH); i++) begin
         phys_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      end
      phys_mem[2] = 32'hDEAD_BEEF;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = phys_mem[i];

      rst = 1'b1;
      idle_all();
      cyc();
      cyc();
      chk("rst_gnt", 32'({g1, g0, wq}), 32'h0);
      chk("rst_outputs", 32'({m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}), 32'h0);
      rst = 1'b0;

      // single read of word 2
      drv(0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
      cyc();
      chk("rd_gnt0", 32'(g0), 32'h1);
      chk("rd_rvalid", 32'(m0_rvalid_o), 32'h1);
      chk("rd_rdata", m0_rdata_o, 32'hDEAD_BEEF);
      chk("rd_err", 32'(m0_err_o), 32'h0);
      idle_all();

      // write from port 1 then read from port 0 in the next cycle
      drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678);
      cyc();
      chk("wr_gnt1", 32'(g1), 32'h1);
      drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      cyc();
      chk("wr_rd_gnt0", 32'(g0), 32'h1);
      chk("wr_rd_rdata", m0_rdata_o, 32'h1234_5678);
      idle_all();

      // misaligned write, then out-of-range write
      drv(0, 1'b1, 1'b1, 1'b0, 32'h6, 32'hFFFF_FFFF);
      cyc();
      chk("mis_gnt0", 32'(g0), 32'h1);
      chk("mis_mem_we", 32'(wq), 32'h0);
      chk("mis_err", 32'(m0_err_o), 32'h1);
      chk("mis_rdata", m0_rdata_o, 32'h0);
      chk("mis_mem1", phys_mem[1], 32'h1000_0111);
      drv(0, 1'b1, 1'b1, 1'b0, 32'h80, 32'hFFFF_FFFF);
      cyc();
      chk("oor_mem_we", 32'(wq), 32'h0);
      chk("oor_err", 32'(m0_err_o), 32'h1);
      chk("oor_rdata", m0_rdata_o, 32'h0);
      idle_all();

      // contention from reset: strict alternation starting with port 0
      do_reset();
      drv(0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      drv(1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("cont_gnt0", 32'(g0), 32'((i % 2) == 0));
         n0 += int'(g0);
         n1 += int'(g1);
      end
      chk("cont_n0", 32'(n0), 32'd4);
      chk("cont_n1", 32'(n1), 32'd4);
      idle_all();

      // lock timeout: port 0 issues 12 locked beats against a busy port 1
      do_reset();
      beats     = 0;
      first1    = -1;
      m0_before = -1;
      drv(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
      drv(1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      for (int i = 0; i < 40 && beats < 12; i++) begin
         cyc();
         if (g0) beats++;
         if (g1 && first1 < 0) begin
            first1    = i;
            m0_before = beats;
         end
         if (beats == 12) drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      chk("lock_first_m1_cycle", 32'(first1), 32'd8);
      chk("lock_m0_run", 32'(m0_before), 32'd8);
      chk("lock_m0_beats", 32'(beats), 32'd12);
      idle_all();

      // reset while port 1 owns the memory
      do_reset();
      drv(1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
      cyc();
      chk("ml_gnt1", 32'(g1), 32'h1);
      drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      chk("ml_own1", 32'({g1, g0}), 32'h2);
      drv(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
      rst = 1'b1;
      cyc();
      chk("ml_rst_gnt_we", 32'({g1, g0, wq}), 32'h0);
      chk("ml_rst_flags", 32'({m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}), 32'h0);
      chk("ml_rst_rdata0", m0_rdata_o, 32'h0);
      chk("ml_rst_rdata1", m1_rdata_o, 32'h0);
      rst = 1'b0;
      cyc();
      chk("ml_after_gnt0", 32'(g0), 32'h1);
      idle_all();

      // random traffic; a requester holds its beat until granted
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            held = (p == 0) ? (m0_req && !g0) : (m1_req && !g1);
            if (!held) begin
               drv(p, ($urandom_range(3) != 0), 1'($urandom_range(1)),
                   ($urandom_range(2) == 0), rand_adr(), $urandom);
            end
         end
         rst = ($urandom_range(99) == 0);
         cyc();
      end
      rst = 1'b0;
      idle_all();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
